// File: rtl/aes_round_sequencer.sv
// Control FSM for the iterative AES round datapath: key expansion into the round-key RAM,
// initial AddRoundKey, then Nr rounds (encrypt or decrypt), caching the expanded schedule.
module aes_round_sequencer #(
  parameter int unsigned RK_AW  = 4,
  parameter int unsigned NR_128 = 10,
  parameter int unsigned NR_192 = 12,
  parameter int unsigned NR_256 = 14
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             decrypt,
  input  logic [1:0]       key_size,
  input  logic             new_key,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic             rk_we,
  output logic [RK_AW-1:0] rk_addr,
  output logic             ld_in,
  output logic             rnd_en,
  output logic             rnd_last,
  output logic             inv,
  output logic             out_we
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_KEXP  = 3'd1;
  localparam logic [2:0] S_LOAD  = 3'd2;
  localparam logic [2:0] S_ROUND = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic [1:0]       KS_ILLEGAL = 2'b11;
  localparam logic [RK_AW-1:0] ADDR_ONE   = RK_AW'(1);

  logic [2:0]       state_q, state_d;
  logic [RK_AW-1:0] addr_q, addr_d;
  logic             dec_q, dec_d;
  logic [1:0]       ks_op_q, ks_op_d;     // key size of the operation in flight
  logic [1:0]       ks_key_q, ks_key_d;   // key size the cached schedule was expanded for
  logic             key_valid_q, key_valid_d;
  logic             error_q, error_d;
  logic [RK_AW-1:0] nr;
  logic             round_last;

  always_comb begin
    case (ks_op_q)
      2'b01:   nr = RK_AW'(NR_192);
      2'b10:   nr = RK_AW'(NR_256);
      default: nr = RK_AW'(NR_128);
    endcase
  end

  // Encrypt walks keys upward ending at Nr; decrypt walks downward ending at 0.
  assign round_last = dec_q ? (addr_q == '0) : (addr_q == nr);

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    dec_d       = dec_q;
    ks_op_d     = ks_op_q;
    ks_key_d    = ks_key_q;
    key_valid_d = key_valid_q;
    error_d     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (key_size == KS_ILLEGAL) begin
            error_d = 1'b1;
          end else begin
            dec_d   = decrypt;
            ks_op_d = key_size;
            if (new_key || !key_valid_q || (key_size != ks_key_q)) begin
              state_d = S_KEXP;
              addr_d  = '0;
            end else begin
              state_d = S_LOAD;
            end
          end
        end
      end
      S_KEXP: begin
        if (addr_q == nr) begin
          key_valid_d = 1'b1;
          ks_key_d    = ks_op_q;
          state_d     = S_LOAD;
        end else begin
          addr_d = addr_q + ADDR_ONE;
        end
      end
      S_LOAD: begin
        state_d = S_ROUND;
        addr_d  = dec_q ? (nr - ADDR_ONE) : ADDR_ONE;
      end
      S_ROUND: begin
        if (round_last) begin
          state_d = S_DONE;
        end else begin
          addr_d = dec_q ? (addr_q - ADDR_ONE) : (addr_q + ADDR_ONE);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // A partially written schedule must never be reused.
    if (abort && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      if (state_q == S_KEXP) begin
        key_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      dec_q       <= 1'b0;
      ks_op_q     <= 2'b00;
      ks_key_q    <= 2'b00;
      key_valid_q <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      dec_q       <= dec_d;
      ks_op_q     <= ks_op_d;
      ks_key_q    <= ks_key_d;
      key_valid_q <= key_valid_d;
      error_q     <= error_d;
    end
  end

  always_comb begin
    busy     = (state_q == S_KEXP) || (state_q == S_LOAD) || (state_q == S_ROUND);
    rk_we    = (state_q == S_KEXP);
    ld_in    = (state_q == S_LOAD);
    rnd_en   = (state_q == S_ROUND);
    rnd_last = (state_q == S_ROUND) && round_last;
    done     = (state_q == S_DONE);
    out_we   = (state_q == S_DONE);
    inv      = dec_q;
    error    = error_q;
    case (state_q)
      S_KEXP, S_ROUND: rk_addr = addr_q;
      S_LOAD:          rk_addr = dec_q ? nr : '0;
      default:         rk_addr = '0;
    endcase
  end

endmodule
